// File: rtl/gravity_step_sequencer_if.sv
// Bus between the gravity step sequencer, the shared force calculator and the register bank.
// The sequencer takes the slave modport; the simulator side takes the master modport.
interface gravity_step_sequencer_if #(
  parameter int IDX_W   = 3,
  parameter int FORCE_W = 14
);
  logic               step_tick;
  logic [FORCE_W-1:0] x_force_in;
  logic [FORCE_W-1:0] y_force_in;
  logic [IDX_W-1:0]   obj_sel;
  logic [IDX_W-1:0]   other_sel;
  logic [FORCE_W-1:0] acc_x;
  logic [FORCE_W-1:0] acc_y;
  logic               commit;
  logic               busy;
  logic               sweep_done;

  modport slave (
    input  step_tick, x_force_in, y_force_in,
    output obj_sel, other_sel, acc_x, acc_y, commit, busy, sweep_done
  );

  modport master (
    output step_tick, x_force_in, y_force_in,
    input  obj_sel, other_sel, acc_x, acc_y, commit, busy, sweep_done
  );
endinterface

// File: rtl/gravity_step_sequencer.sv
// Steps one shared force calculator over every (object, partner) pair.
// Forces are accumulated per object, then committed to the register bank in a single cycle.
module gravity_step_sequencer #(
  parameter int N_OBJ   = 8,
  parameter int IDX_W   = 3,
  parameter int FORCE_W = 14
) (
  input logic clock,
  input logic reset,
  gravity_step_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  state_t             state;
  logic               pending;
  logic               self_pair;
  logic [FORCE_W-1:0] x_term;
  logic [FORCE_W-1:0] y_term;

  // An object exerts no force on itself, whatever the calculator reports for that pair.
  assign self_pair = (bus.other_sel == bus.obj_sel);
  assign x_term    = self_pair ? '0 : bus.x_force_in;
  assign y_term    = self_pair ? '0 : bus.y_force_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      pending        <= 1'b0;
      bus.obj_sel    <= '0;
      bus.other_sel  <= '0;
      bus.acc_x      <= '0;
      bus.acc_y      <= '0;
      bus.commit     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.sweep_done <= 1'b0;
    end else begin
      bus.commit     <= 1'b0;
      bus.sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.step_tick) begin
            state         <= ACCUM;
            bus.busy      <= 1'b1;
            bus.obj_sel   <= '0;
            bus.other_sel <= '0;
            bus.acc_x     <= '0;
            bus.acc_y     <= '0;
          end
        end
        ACCUM: begin
          if (bus.step_tick) pending <= 1'b1;
          bus.acc_x     <= bus.acc_x + x_term;
          bus.acc_y     <= bus.acc_y + y_term;
          bus.other_sel <= bus.other_sel + 1'b1;
          if (bus.other_sel == LAST_IDX) begin
            state          <= COMMIT;
            bus.commit     <= 1'b1;
            bus.sweep_done <= (bus.obj_sel == LAST_IDX);
          end
        end
        COMMIT: begin
          bus.other_sel <= '0;
          bus.acc_x     <= '0;
          bus.acc_y     <= '0;
          if (bus.obj_sel != LAST_IDX) begin
            state       <= ACCUM;
            bus.obj_sel <= bus.obj_sel + 1'b1;
            if (bus.step_tick) pending <= 1'b1;
          end else if (pending || bus.step_tick) begin
            // A tick queued during the sweep, or arriving on its last commit, chains the next sweep.
            state       <= ACCUM;
            bus.obj_sel <= '0;
            pending     <= 1'b0;
          end else begin
            state       <= IDLE;
            bus.obj_sel <= '0;
            bus.busy    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gravity_step_sequencer.sv
// Directed bench for gravity_step_sequencer: sweep vectors from a table plus
// hand-written sequences for queued ticks and mid-sweep reset.
module tb_gravity_step_sequencer;
  localparam int N_OBJ   = 8;
  localparam int IDX_W   = 3;
  localparam int FORCE_W = 14;
  localparam int OBJ_LEN = N_OBJ + 1;
  localparam int SWEEP   = N_OBJ * OBJ_LEN;

  typedef struct {
    logic                        ramp;
    logic [FORCE_W-1:0]          x_val;
    logic [FORCE_W-1:0]          y_val;
    logic [N_OBJ-1:0][FORCE_W-1:0] exp_x;
    logic [N_OBJ-1:0][FORCE_W-1:0] exp_y;
  } vec_t;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               ramp_mode = 1'b0;
  logic [FORCE_W-1:0] x_const = '0;
  logic [FORCE_W-1:0] y_const = '0;
  int                 compared = 0;
  int                 mismatched = 0;
  vec_t               vecs[4];

  always #5 clock = ~clock;

  gravity_step_sequencer_if #(.IDX_W(IDX_W), .FORCE_W(FORCE_W)) bus ();

  gravity_step_sequencer #(.N_OBJ(N_OBJ), .IDX_W(IDX_W), .FORCE_W(FORCE_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Stand-in for the shared calculator: either constants or a ramp keyed on the partner index.
  always_comb begin
    bus.x_force_in = x_const;
    if (ramp_mode) bus.x_force_in = FORCE_W'(bus.other_sel) + FORCE_W'(1);
    bus.y_force_in = y_const;
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic ramp, input logic [FORCE_W-1:0] x, input logic [FORCE_W-1:0] y);
    ramp_mode = ramp;
    x_const   = x;
    y_const   = y;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pulse_tick();
    bus.step_tick = 1'b1;
    next_cycle();
    bus.step_tick = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output($sformatf("%s obj_sel", tag), 32'(bus.obj_sel), 0);
    check_output($sformatf("%s other_sel", tag), 32'(bus.other_sel), 0);
    check_output($sformatf("%s acc_x", tag), 32'(bus.acc_x), 0);
    check_output($sformatf("%s acc_y", tag), 32'(bus.acc_y), 0);
    check_output($sformatf("%s commit", tag), 32'(bus.commit), 0);
    check_output($sformatf("%s busy", tag), 32'(bus.busy), 0);
    check_output($sformatf("%s sweep_done", tag), 32'(bus.sweep_done), 0);
  endtask

  // Two back-to-back sweeps driven by a start tick plus extra ticks at cycles t1/t2 (0 = none).
  task automatic run_pending(input int t1, input int t2);
    bit exp_commit;
    apply_stimulus(1'b0, 14'h0001, 14'h0001);
    pulse_tick();
    for (int n = 1; n <= 2 * SWEEP + 1; n++) begin
      bus.step_tick = (n == t1) || (n == t2);
      exp_commit = (n % OBJ_LEN == 0) && (n <= 2 * SWEEP);
      check_output($sformatf("pend%0d commit@%0d", t1, n), 32'(bus.commit), 32'(exp_commit));
      check_output($sformatf("pend%0d busy@%0d", t1, n), 32'(bus.busy), 32'(n <= 2 * SWEEP));
      check_output($sformatf("pend%0d sweep_done@%0d", t1, n), 32'(bus.sweep_done),
                   32'((n == SWEEP) || (n == 2 * SWEEP)));
      if (exp_commit) begin
        check_output($sformatf("pend%0d obj_sel@%0d", t1, n), 32'(bus.obj_sel), 32'((n / OBJ_LEN - 1) % N_OBJ));
        check_output($sformatf("pend%0d acc_x@%0d", t1, n), 32'(bus.acc_x), 32'h7);
      end
      if (n <= 2 * SWEEP) next_cycle();
    end
    bus.step_tick = 1'b0;
  endtask

  initial begin
    bit exp_commit;
    int k;

    vecs[0] = '{1'b0, 14'h0001, 14'h0001, {N_OBJ{14'h0007}}, {N_OBJ{14'h0007}}};
    vecs[1] = '{1'b1, 14'h0000, 14'h3FFE,
                {14'd28, 14'd29, 14'd30, 14'd31, 14'd32, 14'd33, 14'd34, 14'd35},
                {N_OBJ{14'h3FF2}}};
    vecs[2] = '{1'b0, 14'h1000, 14'h1000, {N_OBJ{14'h3000}}, {N_OBJ{14'h3000}}};
    vecs[3] = '{1'b0, 14'h3FFF, 14'h0800, {N_OBJ{14'h3FF9}}, {N_OBJ{14'h3800}}};

    bus.step_tick = 1'b0;
    apply_stimulus(1'b0, '0, '0);
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    check_all_zero("reset");
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      check_all_zero($sformatf("idle%0d", i));
    end

    for (int v = 0; v < 4; v++) begin
      apply_stimulus(vecs[v].ramp, vecs[v].x_val, vecs[v].y_val);
      pulse_tick();
      check_output($sformatf("v%0d start other_sel", v), 32'(bus.other_sel), 0);
      check_output($sformatf("v%0d start acc_x", v), 32'(bus.acc_x), 0);
      for (int n = 1; n <= SWEEP + 1; n++) begin
        exp_commit = (n % OBJ_LEN == 0) && (n <= SWEEP);
        check_output($sformatf("v%0d commit@%0d", v, n), 32'(bus.commit), 32'(exp_commit));
        check_output($sformatf("v%0d busy@%0d", v, n), 32'(bus.busy), 32'(n <= SWEEP));
        check_output($sformatf("v%0d sweep_done@%0d", v, n), 32'(bus.sweep_done), 32'(n == SWEEP));
        if (exp_commit) begin
          k = n / OBJ_LEN - 1;
          check_output($sformatf("v%0d obj_sel@%0d", v, n), 32'(bus.obj_sel), 32'(k));
          check_output($sformatf("v%0d acc_x obj%0d", v, k), 32'(bus.acc_x), 32'(vecs[v].exp_x[k]));
          check_output($sformatf("v%0d acc_y obj%0d", v, k), 32'(bus.acc_y), 32'(vecs[v].exp_y[k]));
        end
        if (n <= SWEEP) next_cycle();
      end
    end

    run_pending(30, 40);
    run_pending(SWEEP, 0);

    // Reset during the third object's accumulation, then restart from a fresh tick.
    apply_stimulus(1'b0, 14'h0001, 14'h0001);
    pulse_tick();
    for (int n = 1; n <= 34; n++) begin
      reset = (n == 20);
      bus.step_tick = (n == 25);
      if (n == 21) check_all_zero("post_reset");
      exp_commit = (n == 9) || (n == 18) || (n == 34);
      check_output($sformatf("rst commit@%0d", n), 32'(bus.commit), 32'(exp_commit));
      check_output($sformatf("rst busy@%0d", n), 32'(bus.busy), 32'((n <= 20) || (n >= 26)));
      if (n == 34) begin
        check_output("rst restart obj_sel", 32'(bus.obj_sel), 0);
        check_output("rst restart acc_x", 32'(bus.acc_x), 32'h7);
      end
      if (n < 34) next_cycle();
    end
    reset = 1'b0;
    bus.step_tick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
